// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a uart transmitter: buffers producer writes and issues one
// tx_send pulse per byte, waiting for the uart to go busy and then idle again.
module uart_tx_fifo #(
    parameter int ADDR_W       = 4,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        wr_data,
    input  logic              wr_en,
    input  logic              ovf_clr,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [7:0]        tx_data,
    output logic              tx_send,
    input  logic              tx_busy
);

    // state   | meaning
    // IDLE    | waiting for a queued byte and an idle uart
    // SEND    | tx_send pulse is on the wire this cycle
    // WAIT_HI | waiting for the uart to acknowledge by raising tx_busy
    // WAIT_LO | uart transmitting, waiting for tx_busy to drop
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SEND    = 2'd1;
    localparam logic [1:0] ST_WAIT_HI = 2'd2;
    localparam logic [1:0] ST_WAIT_LO = 2'd3;

    localparam int DEPTH = 1 << ADDR_W;
    localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(BUSY_TIMEOUT - 1);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_nxt;
    logic [1:0]        state;
    logic [TMR_W-1:0]  timer;
    logic              wr_acc;
    logic              pop;

    // Full is the registered flag, so a write is dropped even if a pop frees a slot this cycle.
    assign wr_acc = wr_en && !full;
    assign pop    = (state == ST_IDLE) && !empty && !tx_busy;

    always_comb begin
        count_nxt = count;
        if (wr_acc && !pop)
            count_nxt = count + (ADDR_W + 1)'(1);
        else if (pop && !wr_acc)
            count_nxt = count - (ADDR_W + 1)'(1);
    end

    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + ADDR_W'(1);
            count <= count_nxt;
            full  <= (count_nxt == CNT_FULL);
            empty <= (count_nxt == '0);
            if (wr_en && full)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            tx_send <= 1'b0;
            tx_data <= 8'h00;
            timer   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        tx_data <= mem[rd_ptr];
                        tx_send <= 1'b1;
                        state   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    tx_send <= 1'b0;
                    timer   <= TMR_LOAD;
                    state   <= ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    // Timeout covers a uart that missed the pulse or finished within a cycle.
                    if (tx_busy)
                        state <= ST_WAIT_LO;
                    else if (timer == '0)
                        state <= ST_IDLE;
                    else
                        timer <= timer - TMR_W'(1);
                end
                ST_WAIT_LO: begin
                    if (!tx_busy)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: latency, full/overflow, ordered draining,
// coincident push/pop, busy timeout and asynchronous reset abort.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_en = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic [7:0] tx_data;
    logic       tx_send;
    logic       tx_busy;

    // uart model: busy for 20 cycles, rising two edges after tx_send
    logic hold = 1'b0;
    logic model_en = 1'b1;
    logic start = 1'b0;
    int   mcnt = 0;
    assign tx_busy = hold | (model_en & (mcnt != 0));

    int n_checks = 0;
    int n_fail = 0;

    uart_tx_fifo #(.ADDR_W(4), .BUSY_TIMEOUT(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .ovf_clr  (ovf_clr),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .tx_data  (tx_data),
        .tx_send  (tx_send),
        .tx_busy  (tx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start <= 1'b0;
            mcnt  <= 0;
        end else begin
            start <= tx_send;
            if (start)
                mcnt <= 20;
            else if (mcnt != 0)
                mcnt <= mcnt - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_count"},    32'(count),    32'd0);
        check({tag, "_empty"},    32'(empty),    32'd1);
        check({tag, "_full"},     32'(full),     32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
        check({tag, "_tx_send"},  32'(tx_send),  32'd0);
        check({tag, "_tx_data"},  32'(tx_data),  32'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int last;
        int gap;
        int pulses;

        // reset
        #12;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick;

        // 1: single byte latency
        wr_data = 8'hA5; wr_en = 1'b1;
        tick;
        wr_en = 1'b0;
        check("t1_empty_n1", 32'(empty), 32'd0);
        check("t1_count_n1", 32'(count), 32'd1);
        check("t1_send_n1",  32'(tx_send), 32'd0);
        tick;
        check("t1_send_n2",  32'(tx_send), 32'd1);
        check("t1_data_n2",  32'(tx_data), 32'hA5);
        check("t1_count_n2", 32'(count), 32'd0);
        tick;
        check("t1_send_n3",  32'(tx_send), 32'd0);
        check("t1_data_held", 32'(tx_data), 32'hA5);

        // 2: fill while uart busy, overflow
        hold = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_data = 8'(i); wr_en = 1'b1;
            tick;
        end
        wr_en = 1'b0;
        check("t2_full",  32'(full),  32'd1);
        check("t2_count", 32'(count), 32'd16);
        check("t2_ovf0",  32'(overflow), 32'd0);
        wr_data = 8'hFF; wr_en = 1'b1;
        tick;
        wr_en = 1'b0;
        check("t2_ovf1",   32'(overflow), 32'd1);
        check("t2_count2", 32'(count), 32'd16);
        wr_data = 8'hFE; wr_en = 1'b1; ovf_clr = 1'b1;
        tick;
        wr_en = 1'b0;
        check("t2_ovf_drop_wins", 32'(overflow), 32'd1);
        tick;
        ovf_clr = 1'b0;
        check("t2_ovf_clr", 32'(overflow), 32'd0);

        // 3: drain with uart model
        hold = 1'b0;
        idx = 0; last = 0;
        for (int c = 1; c <= 700 && idx < 16; c++) begin
            tick;
            if (tx_send) begin
                check("t3_data", 32'(tx_data), 32'(idx));
                if (idx > 0)
                    check("t3_spacing_ge24", 32'(c - last >= 24), 32'd1);
                last = c;
                idx++;
            end
        end
        check("t3_pulses", 32'(idx), 32'd16);
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            tick;
            if (tx_send) pulses++;
        end
        check("t3_no_extra", 32'(pulses), 32'd0);
        check("t3_empty", 32'(empty), 32'd1);

        // 4: coincident write/pop
        model_en = 1'b0; hold = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_data = 8'(8'h10 + i); wr_en = 1'b1;
            tick;
        end
        wr_en = 1'b0;
        check("t4_count16", 32'(count), 32'd16);
        wr_data = 8'hEE; wr_en = 1'b1; hold = 1'b0;
        tick;
        wr_en = 1'b0; hold = 1'b1;
        check("t4_send", 32'(tx_send), 32'd1);
        check("t4_data", 32'(tx_data), 32'h10);
        check("t4_count15", 32'(count), 32'd15);
        check("t4_ovf", 32'(overflow), 32'd1);
        check("t4_full0", 32'(full), 32'd0);
        tick; tick;
        for (int k = 1; k <= 7; k++) begin
            hold = 1'b0;
            tick; tick;
            hold = 1'b1;
            check("t4_drain_data", 32'(tx_data), 32'(8'h10 + k));
            tick; tick;
        end
        check("t4_count8", 32'(count), 32'd8);
        hold = 1'b0;
        tick;
        wr_data = 8'h55; wr_en = 1'b1;
        tick;
        wr_en = 1'b0; hold = 1'b1;
        check("t4_wp_send", 32'(tx_send), 32'd1);
        check("t4_wp_data", 32'(tx_data), 32'h18);
        check("t4_wp_count", 32'(count), 32'd8);

        // 5: busy never rises -> timeout
        rst_n = 1'b0; #2; rst_n = 1'b1;
        model_en = 1'b0; hold = 1'b0;
        tick;
        wr_data = 8'hC1; wr_en = 1'b1;
        tick;
        wr_data = 8'hC2;
        tick;
        wr_en = 1'b0;
        check("t5_send1", 32'(tx_send), 32'd1);
        check("t5_data1", 32'(tx_data), 32'hC1);
        check("t5_count1", 32'(count), 32'd1);
        gap = 0;
        for (int i = 1; i <= 20; i++) begin
            tick;
            if (tx_send) begin
                gap = i;
                break;
            end
        end
        check("t5_gap", 32'(gap), 32'd10);
        check("t5_data2", 32'(tx_data), 32'hC2);
        repeat (12) tick;
        check("t5_empty", 32'(empty), 32'd1);
        check("t5_idle_send", 32'(tx_send), 32'd0);

        // 6: reset abort in WAIT_LO
        rst_n = 1'b0; #2; rst_n = 1'b1;
        model_en = 1'b1; hold = 1'b0;
        tick;
        for (int i = 0; i < 6; i++) begin
            wr_data = 8'(8'h60 + i); wr_en = 1'b1;
            tick;
        end
        wr_en = 1'b0;
        repeat (4) tick;
        check("t6_count5", 32'(count), 32'd5);
        rst_n = 1'b0;
        #1;
        check_reset_vals("t6_abort");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            tick;
            if (tx_send) pulses++;
        end
        check("t6_no_send", 32'(pulses), 32'd0);
        wr_data = 8'h77; wr_en = 1'b1;
        tick;
        wr_en = 1'b0;
        gap = 0;
        for (int i = 1; i <= 10; i++) begin
            tick;
            if (tx_send) begin
                gap = i;
                break;
            end
        end
        check("t6_new_gap", 32'(gap), 32'd1);
        check("t6_new_data", 32'(tx_data), 32'h77);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
